ascon_input_packer: RTL

//  Upstream feeder for the ASCON-128 top level. Accepts a byte stream: an associated-data
//  (AD) section, then a plaintext (PT) section. Packs each section MSB-first into 64-bit

---
 rtl/ascon_input_packer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ascon_input_packer.sv
// =============================================================================
// Module : ascon_input_packer
// Packs an AD/PT byte stream into padded 64-bit ASCON blocks and paces them to the core.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module ascon_input_packer #(
  parameter int START_GAP = 18,
  parameter int BLOCK_GAP = 10
) (
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic        msg_start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_type_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  input  logic        core_ready_i,
  output logic        start_o,
  output logic [63:0] data_o,
  output logic        data_valid_o,
  output logic        pt_phase_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int GAP_MAX = (START_GAP > BLOCK_GAP) ? START_GAP : BLOCK_GAP;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_PADBLK = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [63:0] PAD_BLOCK = 64'h8000_0000_0000_0000;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [2:0]       cnt;
  logic [GAP_W-1:0] gap;
  logic [63:0]      shreg;
  logic [63:0]      data_q;
  logic             pad_pending;
  logic             last_block;
  logic             pt_phase;
  logic             ad_closed;
  logic             err;

  logic             xfer;
  logic             mismatch;
  logic             accept;
  logic             fire;
  logic [63:0]      blk;
  logic [5:0]       byte_pos;
  logic [5:0]       pad_pos;

  assign xfer     = (state == S_FILL) && byte_valid_i;
  assign mismatch = (byte_type_i != ad_closed);
  assign accept   = xfer && !mismatch;
  assign fire     = ((state == S_ISSUE) || (state == S_PADBLK)) && (gap == '0) && core_ready_i;
  assign blk      = (state == S_PADBLK) ? PAD_BLOCK : shreg;
  assign byte_pos = {3'd7 - cnt, 3'b000};
  assign pad_pos  = {3'd6 - cnt, 3'b000};

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (msg_start_i) state_nxt = S_START;
      S_START:  state_nxt = S_FILL;
      S_FILL:   if (accept && (byte_last_i || (cnt == 3'd7))) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (fire) begin
          if (pad_pending)                  state_nxt = S_PADBLK;
          else if (last_block && pt_phase)  state_nxt = S_DONE;
          else                              state_nxt = S_FILL;
        end
      end
      S_PADBLK: if (fire) state_nxt = pt_phase ? S_DONE : S_FILL;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      cnt         <= '0;
      gap         <= '0;
      shreg       <= '0;
      data_q      <= '0;
      pad_pending <= 1'b0;
      last_block  <= 1'b0;
      pt_phase    <= 1'b0;
      ad_closed   <= 1'b0;
      err         <= 1'b0;
    end else begin
      // The issue cycle counts toward the block gap, hence BLOCK_GAP-1.
      if (state == S_START)  gap <= GAP_W'(START_GAP);
      else if (fire)         gap <= GAP_W'(BLOCK_GAP - 1);
      else if (gap != '0)    gap <= gap - 1'b1;

      if ((state == S_IDLE) && msg_start_i) err <= 1'b0;

      if (xfer) begin
        if (mismatch) begin
          err <= 1'b1;
        end else begin
          shreg[byte_pos +: 8] <= byte_i;
          cnt <= cnt + 3'd1;
          if (byte_last_i) begin
            last_block <= 1'b1;
            if (!byte_type_i) ad_closed <= 1'b1;
            if (cnt == 3'd7) pad_pending <= 1'b1;
            else             shreg[pad_pos +: 8] <= 8'h80;
          end
        end
      end

      if (fire) begin
        data_q <= blk;
        shreg  <= '0;
        cnt    <= '0;
        if (state == S_PADBLK) begin
          pad_pending <= 1'b0;
          pt_phase    <= 1'b1;
        end else if (!pad_pending) begin
          last_block <= 1'b0;
          if (last_block) pt_phase <= 1'b1;
        end else begin
          last_block <= 1'b0;
        end
      end

      if (state == S_DONE) begin
        pt_phase   <= 1'b0;
        ad_closed  <= 1'b0;
        last_block <= 1'b0;
      end
    end
  end

  always_comb begin
    start_o      = 1'b0;
    byte_ready_o = 1'b0;
    data_valid_o = fire;
    busy_o       = (state != S_IDLE);
    data_o       = fire ? blk : data_q;
    case (state)
      S_START: start_o      = 1'b1;
      S_FILL:  byte_ready_o = 1'b1;
      default: ;
    endcase
  end

  assign pt_phase_o = pt_phase;
  assign err_o      = err;

endmodule

`default_nettype wire
